bootrom_arbiter: RTL



---
 rtl/bootrom_arbiter_if.sv | 39 +++
 rtl/bootrom_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bootrom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_arbiter_if
// Description : Bundle of the IF/MEM read ports and the single-port ROM port
//               shared by bootrom_arbiter. The slave modport is the arbiter
//               view; the master modport is the CPU/ROM-side view.
// Revision    : 1.0 - initial release
// ============================================================================
interface bootrom_arbiter_if #(
  parameter int ROM_ADDR_WIDTH = 12
);
  // Instruction-fetch port
  logic                      if_req;
  logic [31:0]               if_addr;
  logic                      if_ack;
  logic [31:0]               if_data;
  // Data (load) port
  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_ack;
  logic [31:0]               mem_data;
  // Shared single-port ROM
  logic                      rom_en;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [31:0]               rom_data;
  // Status
  logic                      busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_addr, rom_data,
    output if_ack, if_data, mem_ack, mem_data, rom_en, rom_addr, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_addr, rom_data,
    input  if_ack, if_data, mem_ack, mem_data, rom_en, rom_addr, busy
  );
endinterface
`default_nettype wire

// File: rtl/bootrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bootrom_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous boot
//               ROM between the instruction-fetch and data read ports. Fixed
//               three-cycle request-to-ack latency, one-cycle ack pulses and
//               per-port held read-data registers.
// Revision    : 1.0 - initial release
// ============================================================================
module bootrom_arbiter #(
  parameter int ROM_ADDR_WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  bootrom_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Port identifiers used for owner and last_grant
  localparam logic c_port_if  = 1'b0;
  localparam logic c_port_mem = 1'b1;

  state_t                    state_q,      state_d;
  logic                      owner_q,      owner_d;
  logic                      last_grant_q, last_grant_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic                      if_ack_q,     if_ack_d;
  logic                      mem_ack_q,    mem_ack_d;
  logic [31:0]               if_data_q,    if_data_d;
  logic [31:0]               mem_data_q,   mem_data_d;

  logic w_if_elig;
  logic w_mem_elig;
  logic w_grant_mem;

  // Byte-offset and wrap bits are deliberately dropped from the word address
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.if_addr[31:ROM_ADDR_WIDTH+2], bus.if_addr[1:0],
                                bus.mem_addr[31:ROM_ADDR_WIDTH+2], bus.mem_addr[1:0]};

  // A port that is being acked this cycle sits out, so the other port wins
  assign w_if_elig  = bus.if_req  & ~if_ack_q;
  assign w_mem_elig = bus.mem_req & ~mem_ack_q;

  // Round-robin pick: single eligible port wins, ties go to the non-last grant
  always_comb begin
    w_grant_mem = 1'b0;
    if (w_if_elig && w_mem_elig) begin
      w_grant_mem = (last_grant_q == c_port_if);
    end else if (w_mem_elig) begin
      w_grant_mem = 1'b1;
    end
  end

  // Next-state and datapath updates for the IDLE/READ/WAIT sequence
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;

    case (state_q)
      S_IDLE: begin
        if (w_if_elig || w_mem_elig) begin
          state_d      = S_READ;
          owner_d      = w_grant_mem ? c_port_mem : c_port_if;
          last_grant_d = w_grant_mem ? c_port_mem : c_port_if;
          addr_d       = w_grant_mem ? bus.mem_addr[ROM_ADDR_WIDTH+1:2]
                                     : bus.if_addr[ROM_ADDR_WIDTH+1:2];
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // ROM output is valid now; only the owner's registers are touched
        if (owner_q == c_port_mem) begin
          mem_data_d = bus.rom_data;
          mem_ack_d  = 1'b1;
        end else begin
          if_data_d  = bus.rom_data;
          if_ack_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= c_port_if;
      last_grant_q <= c_port_mem;
      addr_q       <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_data_q    <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_data_q    <= if_data_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // ROM address is held from the last grant so it does not toggle when idle
  assign bus.rom_en   = (state_q == S_READ);
  assign bus.rom_addr = addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.if_ack   = if_ack_q;
  assign bus.if_data  = if_data_q;
  assign bus.mem_ack  = mem_ack_q;
  assign bus.mem_data = mem_data_q;

endmodule
`default_nettype wire
